// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared sizing helpers for the registered stream FIFO
package axis_pkg;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/axis_reg_fifo_mem.sv
// rtl/axis_reg_fifo_mem.sv - circular store behind the output register
// Pointers compare-and-clear so any ENTRIES count wraps correctly.
module axis_reg_fifo_mem
  import axis_pkg::*;
#(
  parameter int ENTRIES = 3,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t wdata,
  input  logic   pop,
  output entry_t rdata,
  output logic   empty,
  output logic   full
);

  localparam int PW = ptr_width(ENTRIES);
  localparam int CW = level_width(ENTRIES);
  localparam logic [PW-1:0] LAST_PTR = PW'(ENTRIES - 1);

  entry_t        store [ENTRIES];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= wdata;
  end

  assign rdata = store[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(ENTRIES));

endmodule

// File: rtl/axis_reg_fifo.sv
// rtl/axis_reg_fifo.sv - registered-output stream FIFO with level/almost-full report
// Optional packet-store mode: define AXIS_REG_FIFO_PKT_EN.
module axis_reg_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_last,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_last,
  output logic [level_width(DEPTH)-1:0] o_level,
  output logic                          o_afull
);

  localparam int LW = level_width(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic                  lst;
  } beat_t;

  beat_t         in_beat;
  beat_t         out_beat;
  beat_t         mem_rdata;
  logic          out_full;
  logic          mem_empty;
  logic          mem_full;
  logic          mem_push;
  logic          mem_pop;
  logic          load;
  logic          in_xfer;
  logic          out_xfer;
  logic          show;
  logic [LW-1:0] level;

  assign in_beat = '{dat: i_data, lst: i_last};

  // Output register occupied implies the store is the only remaining slack.
  assign i_ready  = rst | ~(out_full & mem_full);
  assign in_xfer  = i_valid & i_ready;
  assign o_valid  = out_full & show & ~rst;
  assign out_xfer = o_valid & o_ready;

  assign load     = ~out_full | out_xfer;
  assign mem_pop  = load & ~mem_empty;
  assign mem_push = in_xfer & ~(load & mem_empty);

  axis_reg_fifo_mem #(
    .ENTRIES (DEPTH - 1),
    .entry_t (beat_t)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (mem_push),
    .wdata (in_beat),
    .pop   (mem_pop),
    .rdata (mem_rdata),
    .empty (mem_empty),
    .full  (mem_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_full <= 1'b0;
    end else if (load) begin
      out_full <= ~mem_empty | in_xfer;
    end
  end

  // Oldest stored beat wins; an empty store bypasses the input straight through.
  always_ff @(posedge clk) begin
    if (load) out_beat <= mem_empty ? in_beat : mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      level <= level + LW'(in_xfer) - LW'(out_xfer);
    end
  end

`ifdef AXIS_REG_FIFO_PKT_EN
  logic [LW-1:0] pkt_cnt;
  logic          pkt_open;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      pkt_open <= 1'b0;
    end else begin
      pkt_cnt <= pkt_cnt + LW'(in_xfer & i_last) - LW'(out_xfer & o_last);
      if (out_xfer) pkt_open <= ~o_last;
    end
  end

  // A full buffer releases regardless so over-long packets cannot deadlock.
  assign show = (pkt_cnt != '0) | (level == LW'(DEPTH)) | pkt_open;
`else
  assign show = 1'b1;
`endif

  assign o_data  = out_beat.dat;
  assign o_last  = out_beat.lst;
  assign o_level = rst ? '0 : level;
  assign o_afull = ~rst & (level >= LW'(AFULL_THRESH));

endmodule

// File: doc/axis_reg_fifo.md
Name: axis_reg_fifo

Overview:
- Parametrised successor to the two-entry AXI-Stream skid register.
- Registered-output stream buffer of DEPTH entries with full throughput and a fill-level report.
- Adds an almost-full flag for upstream back-pressure planning and optional packet-store mode.
- Sits between protocol stages wherever more than one beat of slack is required, e.g. across long routing or ahead of variable-latency consumers.

Parameters:
DATA_WIDTH, 64, payload width in bits (>=1).
DEPTH, 4, total storage in beats including the output register (>=2).
AFULL_THRESH, DEPTH-1, level at or above which o_afull asserts (1..DEPTH).

Ports:
clk  in  1  single clock.
rst  in  1  synchronous, active-high reset.
i_valid  in  1  upstream beat valid.
i_ready  out  1  upstream ready; registered, no combinational path from o_ready.
i_data  in  DATA_WIDTH  upstream payload.
i_last  in  1  end-of-packet marker, carried with the beat.
o_valid  out  1  downstream beat valid; registered.
o_ready  in  1  downstream ready.
o_data  out  DATA_WIDTH  downstream payload; registered.
o_last  out  1  downstream end-of-packet marker; registered.
o_level  out  $clog2(DEPTH+1)  beats held, 0..DEPTH.
o_afull  out  1  o_level >= AFULL_THRESH.

Behaviour:
- Reset is synchronous and active-high.
  - In the reset cycle and the cycle after: o_valid=0, o_level=0, o_afull=0 (unless AFULL_THRESH=0, which is illegal), i_ready=1.
  - Data contents are don't-care.
  - Reset mid-transfer discards all stored beats. No beat accepted in the reset cycle is retained.
- Transfers:
  - Input transfer = i_valid && i_ready. Output transfer = o_valid && o_ready.
  - i_ready = (level < DEPTH), computed from registered state only.
  - Per cycle: level_next = level + in_xfer - out_xfer.
- Latency:
  - A beat entering an empty buffer appears on o_valid in the next cycle (1-cycle latency).
  - Sustained throughput is one beat per cycle in both directions.
- Ordering and stability:
  - Strict FIFO order; data and last always travel together.
  - While o_valid && !o_ready, o_data and o_last hold stable.
- Structure:
  - Output register plus a (DEPTH-1)-entry circular RAM/regfile.
  - When the output register is empty or being consumed, the oldest RAM entry is loaded; if the RAM is empty, i_data is loaded directly (bypass).
  - Read/write pointers wrap modulo DEPTH-1.
  - When DEPTH-1 is not a power of two, pointers compare-and-clear rather than overflow.
- Boundary conditions:
  - Full (level=DEPTH) with o_ready=1: i_ready is still 0 that cycle. Acceptance resumes the next cycle, so a full buffer costs one bubble on input.
  - Empty with i_valid: bypass to the output register; no RAM write.
  - Simultaneous in/out at level=1: the output register reloads from i_data; level stays 1.
  - o_afull follows level with the same registered timing; it is not a function of i_valid.

Optional Feature:
Macro AXIS_REG_FIFO_PKT_EN.
- Defined (packet-store mode):
  - A packet counter tracks complete packets held: +1 on input transfer with i_last, -1 on output transfer with o_last.
  - o_valid is withheld until the counter is >0 or level=DEPTH. The full release prevents deadlock on packets longer than DEPTH.
  - Once the first beat of a packet is presented, o_valid stays asserted until o_last is transferred, except when a not-yet-stored beat is awaited (cut-through after a full release).
- Undefined: o_valid = output register occupied; i_last/o_last are only carried. The counter logic is absent.

Decomposition:
- Package axis_pkg holds:
  - the function level_width(depth) = $clog2(depth+1);
  - the beat struct {dat[DATA_WIDTH], lst} as a parametrised typedef via the module-local type parameter pattern.
- One natural sub-module, axis_reg_fifo_mem: (DEPTH-1)x(DATA_WIDTH+1) storage with write pointer, read pointer and empty/full flags. The top level owns the output register, level counter and packet logic.

Test Plan:
- Reset then single beat: i_valid=1, data=0xA5 for one cycle, o_ready=1 -> o_valid=1 the following cycle with 0xA5; o_level 1 then 0.
- Fill: DEPTH=4, o_ready=0, stream 0..5 -> beats 0..3 accepted, i_ready=0 after the 4th, o_level=4, o_afull=1 from level 3. Releasing o_ready yields 0,1,2,3 in order, then 4,5.
- Throughput: random-free back-to-back 1000 beats with i_valid=o_ready=1 -> 1000 outputs in 1001 cycles, o_level constant 1.
- Random valid/ready (50%/50%, 10k beats) with scoreboard -> no loss, no duplication, o_data stable while stalled; DEPTH in {2,3,5,8}.
- Reset mid-stream: level=3, assert rst one cycle -> o_valid=0, o_level=0 next cycle; no stale beat ever emerges.
- PKT_EN: send a 3-beat packet with gaps, o_ready=1 -> o_valid stays 0 until the last beat is stored, then 3 consecutive beats. A 6-beat packet into DEPTH=4 -> release at full, all 6 delivered.
